// File: rtl/fin_state_machine.sv
// rtl/fin_state_machine.sv - PHT saturating-counter update stage with registered outputs
//
// Purpose:
//   Takes one pattern-history-table counter (in_data) and the resolved branch
//   outcome (torn). Each cycle it computes the next counter value. The result
//   is registered as out_data, with the new prediction bit registered as up_torn.
//   The block holds no table storage. A new update is accepted every cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (0 = outputs cleared)
//   torn      in   resolved outcome, 1 = taken
//   in_data   in   [CNT_W-1:0] current counter read from the PHT
//   up_torn   out  registered prediction, MSB of the updated counter
//   out_data  out  [CNT_W-1:0] registered updated counter
//
// Configuration:
//   FSM_HYST_EN  when defined, a misprediction from a weak state jumps to the
//                opposite strong state instead of stepping by one.

module fin_state_machine #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             torn,
  input  logic [CNT_W-1:0] in_data,
  output logic             up_torn,
  output logic [CNT_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef FSM_HYST_EN
  // Weak states sit on either side of the taken/not-taken midpoint.
  localparam logic [CNT_W-1:0] WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] WEAK_T  = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             pred_d;
  logic             pred_q;

  always_comb begin
    cnt_d = in_data;
    if (torn) begin
      cnt_d = (in_data == CNT_MAX) ? CNT_MAX : in_data + CNT_ONE;
    end else begin
      cnt_d = (in_data == CNT_ZERO) ? CNT_ZERO : in_data - CNT_ONE;
    end
`ifdef FSM_HYST_EN
    if (torn && (in_data == WEAK_NT)) begin
      cnt_d = CNT_MAX;
    end else if (!torn && (in_data == WEAK_T)) begin
      cnt_d = CNT_ZERO;
    end
`endif
    // Prediction is taken from the same next value so the two outputs never disagree.
    pred_d = cnt_d[CNT_W-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= CNT_ZERO;
      pred_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pred_q <= pred_d;
    end
  end

  assign out_data = cnt_q;
  assign up_torn  = pred_q;

endmodule

// File: tb/tb_fin_state_machine.sv
// tb/tb_fin_state_machine.sv - scoreboard bench for fin_state_machine at CNT_W=2 and CNT_W=3

module tb_fin_state_machine;

  logic       clk;
  logic       reset;
  logic       torn;
  logic [1:0] in2;
  logic [2:0] in3;
  logic       up2;
  logic [1:0] out2;
  logic       up3;
  logic [2:0] out3;

  int checks;
  int failures;

  typedef struct {
    int e2;
    int e3;
  } exp_t;

  exp_t sb_q[$];

  fin_state_machine #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .reset    (reset),
    .torn     (torn),
    .in_data  (in2),
    .up_torn  (up2),
    .out_data (out2)
  );

  fin_state_machine #(.CNT_W(3)) dut3 (
    .clk      (clk),
    .reset    (reset),
    .torn     (torn),
    .in_data  (in3),
    .up_torn  (up3),
    .out_data (out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a counter that moves one step toward the outcome and clamps at the ends.
  function automatic int model(int w, int v, bit t, bit rst_n);
    int mx;
    int r;
    mx = (1 << w) - 1;
    if (!rst_n) return 0;
    if (t) r = (v + 1 > mx) ? mx : v + 1;
    else   r = (v - 1 < 0) ? 0 : v - 1;
`ifdef FSM_HYST_EN
    if (t && v == (1 << (w - 1)) - 1) r = mx;
    if (!t && v == (1 << (w - 1)))    r = 0;
`endif
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(bit t, int a2, int a3);
    exp_t e;
    @(negedge clk);
    torn = t;
    in2  = a2[1:0];
    in3  = a3[2:0];
    e.e2 = model(2, a2, t, reset);
    e.e3 = model(3, a3, t, reset);
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are valid one cycle after the inputs, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out2", int'(out2), e.e2);
        check("up2",  int'(up2),  (e.e2 >> 1) & 1);
        check("out3", int'(out3), e.e3);
        check("up3",  int'(up3),  (e.e3 >> 2) & 1);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    torn     = 1'b0;
    in2      = 2'd0;
    in3      = 3'd0;

    #1;
    check("reset_out2_t0", int'(out2), 0);
    check("reset_up2_t0",  int'(up2),  0);

    // Reset held: clocks must not move the outputs off zero.
    for (int i = 0; i < 4; i++) drive(1'b1, 3, 6);

    @(negedge clk);
    reset = 1'b1;

    // Directed tables: taken from every state, then not-taken from every state.
    for (int v = 0; v < 4; v++) drive(1'b1, v, v);
    for (int v = 0; v < 4; v++) drive(1'b0, v, v + 4);

    // Saturation holds at both ends.
    for (int i = 0; i < 3; i++) drive(1'b1, 3, 7);
    for (int i = 0; i < 3; i++) drive(1'b0, 0, 0);

    // Wider counter around the midpoint and the top.
    drive(1'b1, 1, 7);
    drive(1'b0, 2, 4);
    drive(1'b1, 0, 3);
    drive(1'b0, 1, 5);

    // Randomized updates.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    // Mid-cycle reset must clear outputs without a clock edge.
    drive(1'b1, 2, 6);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out2", int'(out2), 0);
    check("midrst_up2",  int'(up2),  0);
    check("midrst_out3", int'(out3), 0);
    check("midrst_up3",  int'(up3),  0);
    drive(1'b1, 2, 6);
    drive(1'b1, 3, 7);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
